// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge: parses 4-byte SPI register-access frames (CMD, {RW,ADDR},
// DATA, TRAILER) into single-cycle register write/read strobes, and returns
// read data to the SPI slave transmit register.
module spi_reg_bridge #(
  parameter logic [7:0]  CMD_BYTE = 8'h89,
  parameter int unsigned ADDR_W   = 7,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rstn_async,
  input  logic              cs_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [7:0]        reg_rdata,
  output logic [7:0]        tx_data,
  output logic              tx_load,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic [CNT_W-1:0]  abort_cnt
);

  typedef enum logic [1:0] {
    S_CMD   = 2'd0,
    S_ADDR  = 2'd1,
    S_DATA  = 2'd2,
    S_TRAIL = 2'd3
  } state_t;

  state_t     state, state_nxt;
  logic       addr_ld;
  logic       data_ld;
  logic       frame_inc;
  logic       abort_inc;
  logic       rw_q;
  logic       re_d;
  logic [7:0] rd_q;

  // State register.
  always_ff @(posedge clk or negedge rstn_async) begin
    if (!rstn_async) state <= S_CMD;
    else             state <= state_nxt;
  end

  // Next state and per-byte actions; deselect takes priority over any byte.
  always_comb begin
    state_nxt = state;
    addr_ld   = 1'b0;
    data_ld   = 1'b0;
    frame_inc = 1'b0;
    abort_inc = 1'b0;
    if (cs_n) begin
      if (state != S_CMD) begin
        state_nxt = S_CMD;
        abort_inc = 1'b1;
      end
    end else if (rx_valid) begin
      case (state)
        S_CMD: begin
          if (rx_data == CMD_BYTE) state_nxt = S_ADDR;
        end
        S_ADDR: begin
          addr_ld   = 1'b1;
          state_nxt = S_DATA;
        end
        S_DATA: begin
          data_ld   = 1'b1;
          state_nxt = S_TRAIL;
        end
        S_TRAIL: begin
          frame_inc = 1'b1;
          state_nxt = S_CMD;
        end
        default: state_nxt = S_CMD;
      endcase
    end
  end

  // Registered strobes, address/data capture, read-back path and counters.
  // Strobes already launched complete even if the frame aborts next cycle.
  always_ff @(posedge clk or negedge rstn_async) begin
    if (!rstn_async) begin
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      tx_data   <= '0;
      tx_load   <= 1'b0;
      frame_cnt <= '0;
      abort_cnt <= '0;
      rw_q      <= 1'b0;
      re_d      <= 1'b0;
      rd_q      <= '0;
    end else begin
      reg_we  <= data_ld & rw_q;
      reg_re  <= addr_ld & ~rx_data[7];
      tx_load <= data_ld & ~rw_q;
      re_d    <= reg_re;
      if (addr_ld) begin
        reg_addr <= rx_data[ADDR_W-1:0];
        rw_q     <= rx_data[7];
      end
      if (data_ld && rw_q)  reg_wdata <= rx_data;
      if (data_ld && !rw_q) tx_data   <= rd_q;
      if (re_d)             rd_q      <= reg_rdata;
      if (frame_inc)        frame_cnt <= frame_cnt + CNT_W'(1);
      if (abort_inc)        abort_cnt <= abort_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Scoreboard bench for spi_reg_bridge: expected strobes are queued as frames
// are driven and checked by a negedge monitor when the DUT emits them.
module tb_spi_reg_bridge;

  logic        clk;
  logic        rstn_async;
  logic        cs_n;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic [6:0]  reg_addr;
  logic [7:0]  reg_wdata;
  logic        reg_we;
  logic        reg_re;
  logic [7:0]  reg_rdata;
  logic [7:0]  tx_data;
  logic        tx_load;
  logic [15:0] frame_cnt;
  logic [15:0] abort_cnt;

  typedef struct {
    logic [6:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t        exp_wr[$];
  logic [6:0] exp_rd[$];
  logic [7:0] exp_tx[$];

  int         vectors    = 0;
  int         miscompares = 0;
  int         cyc        = 0;
  int         rx_cyc     = -100;
  int         exp_frames = 0;
  int         exp_aborts = 0;
  logic [7:0] rd_val     = 8'h00;
  logic       rd_pend    = 1'b0;

  spi_reg_bridge #(
    .CMD_BYTE (8'h89),
    .ADDR_W   (7),
    .CNT_W    (16)
  ) dut (
    .clk        (clk),
    .rstn_async (rstn_async),
    .cs_n       (cs_n),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_we     (reg_we),
    .reg_re     (reg_re),
    .reg_rdata  (reg_rdata),
    .tx_data    (tx_data),
    .tx_load    (tx_load),
    .frame_cnt  (frame_cnt),
    .abort_cnt  (abort_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Register-file model and strobe monitor. reg_rdata carries the real value
  // only on the cycle after reg_re, and its complement otherwise.
  initial begin
    reg_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (rd_pend) begin
        reg_rdata = rd_val;
        rd_pend   = 1'b0;
      end else begin
        reg_rdata = ~rd_val;
      end
      if (reg_we) begin
        vectors++;
        if (exp_wr.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_we: got reg_we=1 addr=%h data=%h, required no write", reg_addr, reg_wdata);
        end else begin
          wr_t e;
          e = exp_wr.pop_front();
          if ({reg_addr, reg_wdata} !== {e.addr, e.data}) begin
            miscompares++;
            $display("FAIL write: got addr=%h data=%h, required addr=%h data=%h", reg_addr, reg_wdata, e.addr, e.data);
          end
        end
        vectors++;
        if (cyc !== rx_cyc) begin
          miscompares++;
          $display("FAIL we_latency: got cycle %0d, required %0d", cyc, rx_cyc);
        end
        vectors++;
        if (reg_re !== 1'b0) begin
          miscompares++;
          $display("FAIL we_re_overlap: got reg_re=%b with reg_we, required 0", reg_re);
        end
      end
      if (reg_re) begin
        rd_pend = 1'b1;
        vectors++;
        if (exp_rd.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_re: got reg_re=1 addr=%h, required no read", reg_addr);
        end else begin
          logic [6:0] ea;
          ea = exp_rd.pop_front();
          if (reg_addr !== ea) begin
            miscompares++;
            $display("FAIL read_addr: got %h, required %h", reg_addr, ea);
          end
        end
        vectors++;
        if (cyc !== rx_cyc) begin
          miscompares++;
          $display("FAIL re_latency: got cycle %0d, required %0d", cyc, rx_cyc);
        end
        vectors++;
        if (tx_load !== 1'b0) begin
          miscompares++;
          $display("FAIL tx_re_overlap: got tx_load=%b with reg_re, required 0", tx_load);
        end
      end
      if (tx_load) begin
        vectors++;
        if (exp_tx.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_tx: got tx_load=1 tx_data=%h, required no load", tx_data);
        end else begin
          logic [7:0] et;
          et = exp_tx.pop_front();
          if (tx_data !== et) begin
            miscompares++;
            $display("FAIL tx_data: got %h, required %h", tx_data, et);
          end
        end
        vectors++;
        if (cyc !== rx_cyc) begin
          miscompares++;
          $display("FAIL tx_latency: got cycle %0d, required %0d", cyc, rx_cyc);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_cyc   = cyc;
    rx_valid = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
    send_byte(b3);
  endtask

  task automatic check_quiet(input string name);
    repeat (6) @(posedge clk);
    #1;
    vectors++;
    if (exp_wr.size() + exp_rd.size() + exp_tx.size() != 0) begin
      miscompares++;
      $display("FAIL %s_pending: got %0d/%0d/%0d outstanding wr/rd/tx, required 0/0/0",
               name, exp_wr.size(), exp_rd.size(), exp_tx.size());
    end
    vectors++;
    if (frame_cnt !== 16'(exp_frames)) begin
      miscompares++;
      $display("FAIL %s_frame_cnt: got %0d, required %0d", name, frame_cnt, exp_frames);
    end
    vectors++;
    if (abort_cnt !== 16'(exp_aborts)) begin
      miscompares++;
      $display("FAIL %s_abort_cnt: got %0d, required %0d", name, abort_cnt, exp_aborts);
    end
  endtask

  task automatic test_reset;
    rstn_async = 1'b0;
    cs_n       = 1'b1;
    rx_valid   = 1'b0;
    rx_data    = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({reg_addr, reg_wdata, reg_we, reg_re, tx_data, tx_load, frame_cnt, abort_cnt} !== '0) begin
      miscompares++;
      $display("FAIL reset: got addr=%h wd=%h we=%b re=%b tx=%h ld=%b fc=%0d ac=%0d, required all 0",
               reg_addr, reg_wdata, reg_we, reg_re, tx_data, tx_load, frame_cnt, abort_cnt);
    end
    @(negedge clk);
    rstn_async = 1'b1;
    cs_n       = 1'b0;
  endtask

  task automatic test_filler_write;
    exp_wr.push_back('{addr: 7'h24, data: 8'h00});
    send_byte(8'h00);
    send_frame(8'h89, 8'hA4, 8'h00, 8'h00);
    exp_frames++;
    check_quiet("filler_write");
  endtask

  task automatic test_back_to_back;
    exp_wr.push_back('{addr: 7'h05, data: 8'h07});
    exp_wr.push_back('{addr: 7'h04, data: 8'h00});
    exp_wr.push_back('{addr: 7'h02, data: 8'h13});
    send_frame(8'h89, 8'h85, 8'h07, 8'h00);
    send_frame(8'h89, 8'h84, 8'h00, 8'h00);
    send_frame(8'h89, 8'h82, 8'h13, 8'h00);
    exp_frames += 3;
    check_quiet("back_to_back");
  endtask

  task automatic test_read;
    rd_val = 8'h5A;
    exp_rd.push_back(7'h48);
    exp_tx.push_back(8'h5A);
    send_frame(8'h89, 8'h48, 8'hC3, 8'h00);
    exp_frames++;
    check_quiet("read");
    vectors++;
    if (reg_addr !== 7'h48) begin
      miscompares++;
      $display("FAIL read_addr_held: got %h, required 48", reg_addr);
    end
  endtask

  task automatic test_abort;
    send_byte(8'h89);
    send_byte(8'h85);
    cs_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    cs_n = 1'b0;
    exp_aborts++;
    check_quiet("abort");
    exp_wr.push_back('{addr: 7'h00, data: 8'h01});
    send_frame(8'h89, 8'h80, 8'h01, 8'h00);
    exp_frames++;
    check_quiet("after_abort");
  endtask

  task automatic test_abort_pending_read;
    // reg_re is already launched when cs_n rises; it must still fire.
    rd_val = 8'h3C;
    exp_rd.push_back(7'h11);
    send_byte(8'h89);
    @(posedge clk);
    #1;
    rx_data  = 8'h11;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_cyc   = cyc;
    rx_valid = 1'b0;
    cs_n     = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    cs_n = 1'b0;
    exp_aborts++;
    check_quiet("abort_pending_read");
    // Byte arriving together with deselect is discarded.
    send_byte(8'h89);
    cs_n = 1'b1;
    send_byte(8'h85);
    cs_n = 1'b0;
    exp_aborts++;
    send_byte(8'h07);
    send_byte(8'h00);
    check_quiet("deselect_byte");
    vectors++;
    if (reg_addr !== 7'h11) begin
      miscompares++;
      $display("FAIL discarded_addr: got %h, required 11", reg_addr);
    end
  endtask

  task automatic test_junk_cmd;
    send_frame(8'h88, 8'h85, 8'h07, 8'h00);
    check_quiet("junk_cmd");
  endtask

  task automatic test_reset_mid_frame;
    send_byte(8'h89);
    send_byte(8'hA4);
    #2;
    rstn_async = 1'b0;
    #1;
    vectors++;
    if ({reg_addr, reg_wdata, reg_we, reg_re, tx_data, tx_load, frame_cnt, abort_cnt} !== '0) begin
      miscompares++;
      $display("FAIL mid_reset: got addr=%h wd=%h we=%b re=%b tx=%h ld=%b fc=%0d ac=%0d, required all 0",
               reg_addr, reg_wdata, reg_we, reg_re, tx_data, tx_load, frame_cnt, abort_cnt);
    end
    exp_frames = 0;
    exp_aborts = 0;
    @(negedge clk);
    rstn_async = 1'b1;
    exp_wr.push_back('{addr: 7'h24, data: 8'hFF});
    send_frame(8'h89, 8'hA4, 8'hFF, 8'h00);
    exp_frames++;
    check_quiet("after_reset");
  endtask

  initial begin
    test_reset;
    test_filler_write;
    test_back_to_back;
    test_read;
    test_abort;
    test_abort_pending_read;
    test_junk_cmd;
    test_reset_mid_frame;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
